// File: rtl/sm_step_pkg.sv
// sm_step_pkg: shared types and constants for the single-step / free-run
// clock-enable controller (sm_step_ctrl and its debounce sub-block).
package sm_step_pkg;

  // Default debounce window: 10 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

  // Width of the stepCnt output.
  localparam int unsigned STEP_CNT_W = 16;

  // Width of the run-mode period select.
  localparam int unsigned DIV_SEL_W = 4;

  // Debounce FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PRESS_DB = 2'b01,
    ST_HELD     = 2'b10,
    ST_REL_DB   = 2'b11
  } db_state_e;

  // Counter width able to hold the value n-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/sm_debounce.sv
// sm_debounce: 2-flop synchronizer plus debounce FSM for an active-low step
// button. held is the debounced button state; pressPulse is a one-cycle pulse
// on every qualified press (PRESS_DB -> HELD).
module sm_debounce
  import sm_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw_n,
  output logic held,
  output logic pressPulse
);

  localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             pressed_c;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_done_c;
  logic             held_q;
  logic             held_d;
  logic             pulse_q;
  logic             pulse_d;

  // Synchronize the asynchronous button; reset value is the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btnRaw_n};
    end
  end

  assign pressed_c  = ~sync_q[1];
  assign cnt_done_c = (cnt_q == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pressed_c) state_d = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!pressed_c)      state_d = ST_IDLE;
        else if (cnt_done_c) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!pressed_c) state_d = ST_REL_DB;
      end
      ST_REL_DB: begin
        if (pressed_c)       state_d = ST_HELD;
        else if (cnt_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, derived from the upcoming state so they register in step with it.
  always_comb begin
    held_d  = (state_d == ST_HELD) || (state_d == ST_REL_DB);
    pulse_d = (state_q == ST_PRESS_DB) && (state_d == ST_HELD);
  end

  // Debounce counter: restarts on every state change, runs in the *_DB states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_PRESS_DB) || (state_q == ST_REL_DB)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      held_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign held       = held_q;
  assign pressPulse = pulse_q;

endmodule

// File: rtl/sm_step_ctrl.sv
// sm_step_ctrl: generates a one-cycle clock-enable strobe for a core, either
// from a debounced step button (runMode=0) or from a prescaler (runMode=1).
// Optional macro SM_STEP_COUNTER_EN builds the stepCnt strobe counter;
// without it stepCnt is constant zero.
module sm_step_ctrl
  import sm_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DIV_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btnRaw_n,
  input  logic                  runMode,
  input  logic [DIV_SEL_W-1:0]  clkDevide,
  output logic                  clkEnable,
  output logic                  btnHeld,
  output logic [STEP_CNT_W-1:0] stepCnt
);

  logic             press_pulse;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] limit_c;
  logic             run_tick_c;
  logic             en_q;
  logic             en_d;

  // Button synchronizer and debounce.
  sm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btnRaw_n  (btnRaw_n),
    .held      (btnHeld),
    .pressPulse(press_pulse)
  );

  // Prescaler: >= compare so a shrinking period ticks immediately.
  always_comb begin
    limit_c    = (DIV_W'(1) << clkDevide) - DIV_W'(1);
    run_tick_c = (div_q >= limit_c);
    div_d      = '0;
    if (runMode && !run_tick_c) begin
      div_d = div_q + DIV_W'(1);
    end
    en_d = runMode ? run_tick_c : press_pulse;
  end

  // Prescaler and enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      en_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      en_q  <= en_d;
    end
  end

  assign clkEnable = en_q;

`ifdef SM_STEP_COUNTER_EN
  logic [STEP_CNT_W-1:0] step_cnt_q;

  // Count issued strobes, wrapping at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else if (en_q) begin
      step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
    end
  end

  assign stepCnt = step_cnt_q;
`else
  assign stepCnt = '0;
`endif

endmodule

// File: tb/tb_sm_step_ctrl.sv
// tb_sm_step_ctrl: directed self-checking bench for sm_step_ctrl with
// DEBOUNCE_CYCLES=4. stepCnt expectations follow SM_STEP_COUNTER_EN.
module tb_sm_step_ctrl;

`ifdef SM_STEP_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        btnRaw_n;
  logic        runMode;
  logic [3:0]  clkDevide;
  logic        clkEnable;
  logic        btnHeld;
  logic [15:0] stepCnt;

  int checks;
  int failures;

  sm_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DIV_W          (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnRaw_n (btnRaw_n),
    .runMode  (runMode),
    .clkDevide(clkDevide),
    .clkEnable(clkEnable),
    .btnHeld  (btnHeld),
    .stepCnt  (stepCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned v);
    return CNT_EN ? 32'(v & 32'hFFFF) : 32'd0;
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    btnRaw_n  = 1'b1;
    runMode   = 1'b0;
    clkDevide = 4'd0;

    // Reset state
    step(3);
    check("reset_en",   32'(clkEnable), 32'd0);
    check("reset_held", 32'(btnHeld),   32'd0);
    check("reset_cnt",  32'(stepCnt),   32'd0);
    rst = 1'b0;
    step(2);
    check("idle_en", 32'(clkEnable), 32'd0);

    // Clean press held 20 cycles: one strobe 7 edges after the first low sample
    btnRaw_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("press_en[%0d]", i),   32'(clkEnable), 32'(i == 7));
      check($sformatf("press_held[%0d]", i), 32'(btnHeld),   32'(i >= 6));
    end
    btnRaw_n = 1'b1;
    step(10);
    check("release_held", 32'(btnHeld), 32'd0);
    check("press_cnt",    32'(stepCnt), exp_cnt(1));

    // Bouncy press: 2 low / 2 high, 5 times, never qualifies
    for (int r = 0; r < 5; r++) begin
      btnRaw_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
        step(1);
        check($sformatf("bounce_en[%0d]", r),   32'(clkEnable), 32'd0);
        check($sformatf("bounce_held[%0d]", r), 32'(btnHeld),   32'd0);
      end
      btnRaw_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        step(1);
        check($sformatf("bounce_en[%0d]", r),   32'(clkEnable), 32'd0);
        check($sformatf("bounce_held[%0d]", r), 32'(btnHeld),   32'd0);
      end
    end
    step(6);
    check("bounce_en_end",   32'(clkEnable), 32'd0);
    check("bounce_held_end", 32'(btnHeld),   32'd0);
    check("bounce_cnt",      32'(stepCnt),   exp_cnt(1));

    // Press in run mode with a long period: tracked but no strobe
    runMode   = 1'b1;
    clkDevide = 4'd15;
    btnRaw_n  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("runpress_en[%0d]", i), 32'(clkEnable), 32'd0);
    end
    check("runpress_held", 32'(btnHeld), 32'd1);
    btnRaw_n = 1'b1;
    runMode  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("runrel_en[%0d]", i), 32'(clkEnable), 32'd0);
    end
    check("runrel_held", 32'(btnHeld), 32'd0);

    // Free-run clkDevide=3: strobe every 8 cycles, 10 strobes in 80 cycles
    rst = 1'b1;
    step(2);
    rst       = 1'b0;
    runMode   = 1'b1;
    clkDevide = 4'd3;
    for (int i = 0; i < 80; i++) begin
      step(1);
      check($sformatf("div3_en[%0d]", i), 32'(clkEnable), 32'((i % 8) == 7));
    end
    runMode = 1'b0;
    step(1);
    check("div3_cnt", 32'(stepCnt), exp_cnt(10));
    check("div3_off", 32'(clkEnable), 32'd0);

    // Period shrink 7 -> 2 at prescaler=50: tick next cycle, then every 4
    step(2);
    runMode   = 1'b1;
    clkDevide = 4'd7;
    step(50);
    check("shrink_pre_en", 32'(clkEnable), 32'd0);
    clkDevide = 4'd2;
    step(1);
    check("shrink_first_en", 32'(clkEnable), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check($sformatf("shrink_en[%0d]", i), 32'(clkEnable), 32'((i % 4) == 0));
    end
    runMode = 1'b0;
    step(2);

    // Free-run clkDevide=0: enable every cycle, counter wraps
    rst = 1'b1;
    step(2);
    rst       = 1'b0;
    runMode   = 1'b1;
    clkDevide = 4'd0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("div0_en[%0d]", i),  32'(clkEnable), 32'd1);
      check($sformatf("div0_cnt[%0d]", i), 32'(stepCnt),   exp_cnt(i));
    end
`ifdef SM_STEP_COUNTER_EN
    step(65534 - 9);
    check("wrap_fffe", 32'(stepCnt), 32'h0000_FFFE);
    step(1);
    check("wrap_ffff", 32'(stepCnt), 32'h0000_FFFF);
    step(1);
    check("wrap_0000", 32'(stepCnt), 32'h0000_0000);
    step(1);
    check("wrap_0001", 32'(stepCnt), 32'h0000_0001);
    check("wrap_en",   32'(clkEnable), 32'd1);
`endif
    runMode = 1'b0;
    step(3);

    // Reset two cycles into press debounce: aborted, then re-qualified
    btnRaw_n = 1'b0;
    step(4);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check($sformatf("rst_en[%0d]", i),   32'(clkEnable), 32'd0);
      check($sformatf("rst_held[%0d]", i), 32'(btnHeld),   32'd0);
      check($sformatf("rst_cnt[%0d]", i),  32'(stepCnt),   32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("requal_en[%0d]", i),   32'(clkEnable), 32'(i == 7));
      check($sformatf("requal_held[%0d]", i), 32'(btnHeld),   32'(i >= 6));
    end
    check("requal_cnt", 32'(stepCnt), exp_cnt(1));
    btnRaw_n = 1'b1;
    step(10);
    check("final_held", 32'(btnHeld), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
